csr_file: RTL and testbench

Control/status register file and exception-commit unit for the LoongArch core. Sits directly downstream of the WB-stage exception encoder: it consumes `wb_ex`, `wb_ecode` and `wb_esubcode` from that encoder. At commit it updates CRMD/PRMD/ESTAT/ERA/BADV and supplies the redirect targets `ex_entry` and `ertn_era` to the front end. It also hosts the interrupt sources and the stable timer that produce `has_int`, which feeds back into the encoder.

---
 rtl/csr_file.sv | 232 +++++++++++++++++++++++
 tb/tb_csr_file.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: LoongArch control/status register file and exception-commit unit.
//
// Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY and SAVE0-3. Optionally
// holds TID, TCFG, TVAL and TICLR. Software accesses these through csr_num,
// csr_we, csr_wmask and csr_wvalue. When an exception or ertn commits, the
// unit updates CRMD, PRMD, ESTAT, ERA and BADV. It also produces the
// front-end redirect targets and the pending-interrupt flag.
//
// Ports
//   clk, reset            single clock; asynchronous active-high reset
//   csr_num               CSR address for the read port and the write port
//   csr_rvalue            combinational read data (unimplemented -> 0)
//   csr_we/wmask/wvalue   masked software write
//   wb_ex, wb_ecode,      exception commit from the WB-stage encoder
//   wb_esubcode, wb_pc,
//   wb_vaddr
//   ertn_flush            ertn commit
//   hw_int_in, ipi_int_in interrupt lines, resampled into ESTAT.IS every cycle
//   has_int               CRMD.IE & |(ESTAT.IS & ECFG.LIE)
//   ex_entry, ertn_era    EENTRY and ERA, used for redirects
//
// Build option
//   CSR_TIMER_EN          when defined, TID/TCFG/TVAL/TICLR and the stable
//                         timer are built. Otherwise those addresses read 0,
//                         writes to them are ignored, and IS[11] is 0.
module csr_file #(
  parameter logic [31:0] CORE_ID = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [7:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_era
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_SAVE1  = 14'h031;
  localparam logic [13:0] ADDR_SAVE2  = 14'h032;
  localparam logic [13:0] ADDR_SAVE3  = 14'h033;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;

  localparam logic [5:0]  ECODE_ADEF  = 6'h08;
  localparam logic [5:0]  ECODE_ALE   = 6'h09;

  // Only the implemented bits are stored; all other bits read as zero.
  logic [4:0]  crmd;            // PG, DA, IE, PLV[1:0]
  logic [2:0]  prmd;            // PIE, PPLV[1:0]
  logic [12:0] ecfg_lie;        // bit 10 is held at 0
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ipi;
  logic        is_timer;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [31:0] save0, save1, save2, save3;

  logic        sw_we;
  logic [31:0] wr_merged;

  assign estat_is = {is_ipi, is_timer, 1'b0, is_hw, is_sw};

`ifdef CSR_TIMER_EN
  logic [31:0] tid;
  logic [31:0] tcfg;
  logic [31:0] tval;
`endif

  // ---------------------------------------------------------------- read
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      ADDR_CRMD:   csr_rvalue = {27'b0, crmd};
      ADDR_PRMD:   csr_rvalue = {29'b0, prmd};
      ADDR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
      ADDR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
      ADDR_ERA:    csr_rvalue = era;
      ADDR_BADV:   csr_rvalue = badv;
      ADDR_EENTRY: csr_rvalue = {eentry, 6'b0};
      ADDR_SAVE0:  csr_rvalue = save0;
      ADDR_SAVE1:  csr_rvalue = save1;
      ADDR_SAVE2:  csr_rvalue = save2;
      ADDR_SAVE3:  csr_rvalue = save3;
`ifdef CSR_TIMER_EN
      ADDR_TID:    csr_rvalue = tid;
      ADDR_TCFG:   csr_rvalue = tcfg;
      ADDR_TVAL:   csr_rvalue = tval;
`endif
      default:     csr_rvalue = '0;
    endcase
  end

  // A software write is dropped when a commit happens in the same cycle.
  assign sw_we = csr_we & ~wb_ex & ~ertn_flush;

  // The masked merge uses the read-port value of the addressed register as
  // "old". Each register then keeps only its writable slice. Bits that read
  // as zero (ECFG bit 10) are cleared again explicitly.
  assign wr_merged = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);

  assign has_int  = crmd[2] & (|(estat_is & ecfg_lie));
  assign ex_entry = {eentry, 6'b0};
  assign ertn_era = era;

  // ------------------------------------------------- architectural state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd           <= 5'h08;
      prmd           <= '0;
      ecfg_lie       <= '0;
      is_sw          <= '0;
      is_hw          <= '0;
      is_ipi         <= 1'b0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
      era            <= '0;
      badv           <= '0;
      eentry         <= '0;
      save0          <= '0;
      save1          <= '0;
      save2          <= '0;
      save3          <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wb_ex) begin
        prmd           <= crmd[2:0];
        crmd[2:0]      <= 3'b000;
        estat_ecode    <= wb_ecode;
        estat_esubcode <= {1'b0, wb_esubcode};
        era            <= wb_pc;
        if (wb_ecode == ECODE_ADEF)
          badv <= wb_pc;
        else if (wb_ecode == ECODE_ALE)
          badv <= wb_vaddr;
      end else if (ertn_flush) begin
        crmd[2:0] <= prmd;
      end else if (csr_we) begin
        case (csr_num)
          ADDR_CRMD:   crmd     <= wr_merged[4:0];
          ADDR_PRMD:   prmd     <= wr_merged[2:0];
          ADDR_ECFG:   ecfg_lie <= wr_merged[12:0] & 13'h1BFF;
          ADDR_ESTAT:  is_sw    <= wr_merged[1:0];
          ADDR_ERA:    era      <= wr_merged;
          ADDR_BADV:   badv     <= wr_merged;
          ADDR_EENTRY: eentry   <= wr_merged[31:6];
          ADDR_SAVE0:  save0    <= wr_merged;
          ADDR_SAVE1:  save1    <= wr_merged;
          ADDR_SAVE2:  save2    <= wr_merged;
          ADDR_SAVE3:  save3    <= wr_merged;
          default: ;
        endcase
      end
    end
  end

  // ------------------------------------------------------- stable timer
`ifdef CSR_TIMER_EN
  logic tcfg_wr;
  logic ticlr_wr;
  logic expire;

  assign tcfg_wr  = sw_we && (csr_num == ADDR_TCFG);
  assign ticlr_wr = sw_we && (csr_num == ADDR_TICLR) && wr_merged[0];
  assign expire   = tcfg[0] && (tval == 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tid      <= CORE_ID;
      tcfg     <= '0;
      tval     <= '1;
      is_timer <= 1'b0;
    end else begin
      if (sw_we && (csr_num == ADDR_TID))
        tid <= wr_merged;

      if (tcfg_wr) begin
        tcfg <= wr_merged;
      end

      // A load from a TCFG write takes precedence over counting. A one-shot
      // expiry just decrements 0 to all-ones, where counting stops.
      if (tcfg_wr && wr_merged[0]) begin
        tval <= {wr_merged[31:2], 2'b00};
      end else if (tcfg[0] && (tval != '1)) begin
        if (expire && tcfg[1])
          tval <= {tcfg[31:2], 2'b00};
        else
          tval <= tval - 32'd1;
      end

      // Expiry wins over a same-cycle TICLR clear.
      if (expire)
        is_timer <= 1'b1;
      else if (ticlr_wr)
        is_timer <= 1'b0;
    end
  end
`else
  // CORE_ID only seeds TID; keep it referenced when the timer is absent.
  logic unused_core_id;
  assign unused_core_id = ^CORE_ID;
  assign is_timer = 1'b0;
`endif

endmodule

// File: tb/tb_csr_file.sv
`timescale 1ns/1ps
module tb_csr_file;

  localparam logic [31:0] CORE_ID = 32'd3;

`ifdef CSR_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [7:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_era;

  always #50 clk = ~clk;

  csr_file #(.CORE_ID(CORE_ID)) dut (
    .clk(clk), .reset(reset), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_era(ertn_era)
  );

  int errors = 0;
  int checks = 0;

  logic [13:0] addrs [17] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006,
                              14'h007, 14'h00C, 14'h030, 14'h031, 14'h032,
                              14'h033, 14'h040, 14'h041, 14'h042, 14'h044,
                              14'h002, 14'h100};

  // ------------------------------------------------ reference model state
  logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv, m_eentry;
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [4];

  function automatic logic [31:0] writable(input logic [13:0] a);
    case (a)
      14'h000: return 32'h0000_001F;
      14'h001: return 32'h0000_0007;
      14'h004: return 32'h0000_1BFF;
      14'h005: return 32'h0000_0003;
      14'h006, 14'h007, 14'h030, 14'h031, 14'h032, 14'h033: return 32'hFFFF_FFFF;
      14'h00C: return 32'hFFFF_FFC0;
      14'h040, 14'h041: return TIMER ? 32'hFFFF_FFFF : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] a);
    case (a)
      14'h000: return m_crmd;
      14'h001: return m_prmd;
      14'h004: return m_ecfg;
      14'h005: return m_estat;
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00C: return m_eentry;
      14'h030: return m_save[0];
      14'h031: return m_save[1];
      14'h032: return m_save[2];
      14'h033: return m_save[3];
      14'h040: return TIMER ? m_tid : 32'h0;
      14'h041: return TIMER ? m_tcfg : 32'h0;
      14'h042: return TIMER ? m_tval : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_has_int();
    return m_crmd[2] & (|(m_estat[12:0] & m_ecfg[12:0]));
  endfunction

  task automatic model_reset();
    m_crmd = 32'h8; m_prmd = '0; m_ecfg = '0; m_estat = '0; m_era = '0;
    m_badv = '0; m_eentry = '0; m_tcfg = '0; m_tid = CORE_ID; m_tval = '1;
    for (int unsigned i = 0; i < 4; i++) m_save[i] = '0;
  endtask

  // One clock's worth of architectural effect of the current inputs.
  task automatic model_step();
    logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_badv, n_eentry;
    logic [31:0] n_tid, n_tcfg, n_tval, m;
    logic [31:0] n_save [4];
    logic loaded;
    n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_estat = m_estat;
    n_era = m_era; n_badv = m_badv; n_eentry = m_eentry; n_tid = m_tid;
    n_tcfg = m_tcfg; n_tval = m_tval; n_save = m_save;
    loaded = 1'b0;
    if (wb_ex) begin
      n_prmd = {29'b0, m_crmd[2:0]};
      n_crmd = {m_crmd[31:3], 3'b000};
      n_estat[30:16] = {1'b0, wb_esubcode, wb_ecode};
      n_era = wb_pc;
      if (wb_ecode == 6'h08) n_badv = wb_pc;
      else if (wb_ecode == 6'h09) n_badv = wb_vaddr;
    end else if (ertn_flush) begin
      n_crmd[2:0] = m_prmd[2:0];
    end else if (csr_we) begin
      m = csr_wmask & writable(csr_num);
      case (csr_num)
        14'h000: n_crmd   = (m_crmd & ~m)   | (csr_wvalue & m);
        14'h001: n_prmd   = (m_prmd & ~m)   | (csr_wvalue & m);
        14'h004: n_ecfg   = (m_ecfg & ~m)   | (csr_wvalue & m);
        14'h005: n_estat  = (m_estat & ~m)  | (csr_wvalue & m);
        14'h006: n_era    = (m_era & ~m)    | (csr_wvalue & m);
        14'h007: n_badv   = (m_badv & ~m)   | (csr_wvalue & m);
        14'h00C: n_eentry = (m_eentry & ~m) | (csr_wvalue & m);
        14'h030, 14'h031, 14'h032, 14'h033:
          n_save[csr_num[1:0]] = (m_save[csr_num[1:0]] & ~m) | (csr_wvalue & m);
        14'h040: n_tid    = (m_tid & ~m)    | (csr_wvalue & m);
        14'h041: begin
          n_tcfg = (m_tcfg & ~m) | (csr_wvalue & m);
          if (TIMER && n_tcfg[0]) begin
            n_tval = {n_tcfg[31:2], 2'b00};
            loaded = 1'b1;
          end
        end
        14'h044: if (TIMER && csr_wmask[0] && csr_wvalue[0]) n_estat[11] = 1'b0;
        default: ;
      endcase
    end
    n_estat[9:2] = hw_int_in;
    n_estat[12]  = ipi_int_in;
    if (TIMER && m_tcfg[0]) begin
      if (m_tval == 32'd0) n_estat[11] = 1'b1;
      if (!loaded) begin
        if (m_tval == 32'd0)
          n_tval = m_tcfg[1] ? {m_tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
        else if (m_tval != 32'hFFFF_FFFF)
          n_tval = m_tval - 32'd1;
      end
    end
    m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_estat = n_estat;
    m_era = n_era; m_badv = n_badv; m_eentry = n_eentry; m_tid = n_tid;
    m_tcfg = n_tcfg; m_tval = n_tval; m_save = n_save;
  endtask

  // Advance one clock: fresh interrupt lines, model update, then the edge.
  task automatic cycle();
    hw_int_in  = 8'($urandom);
    ipi_int_in = 1'($urandom);
    model_step();
    @(posedge clk);
    #1;
    csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] v);
    csr_num = a;
    #1;
    v = csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] mask, input logic [31:0] val);
    csr_num = a; csr_we = 1'b1; csr_wmask = mask; csr_wvalue = val;
    cycle();
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    hw_int_in = '0; ipi_int_in = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 17; i++) begin
      rd(addrs[i], v);
      checks++;
      if (v !== model_read(addrs[i])) begin
        errors++;
        $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], v, model_read(addrs[i]));
      end
    end
    rd(14'h000, v);
    checks++;
    if (v !== 32'h0000_0008) begin
      errors++; $display("FAIL reset_crmd got=%h exp=00000008", v);
    end
`ifdef CSR_TIMER_EN
    rd(14'h040, v);
    checks++;
    if (v !== 32'h0000_0003) begin
      errors++; $display("FAIL reset_tid got=%h exp=00000003", v);
    end
`endif
    checks++;
    if (has_int !== 1'b0 || ex_entry !== 32'h0 || ertn_era !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs has_int=%b ex_entry=%h ertn_era=%h exp 0/0/0", has_int, ex_entry, ertn_era);
    end
    reset = 1'b0;
  endtask

  task automatic test_exception();
    logic [31:0] v;
    wr(14'h000, 32'h7, 32'h7);
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 8'h00; wb_pc = 32'h1C00_0100;
    wb_vaddr = 32'h1234_5678;
    cycle();
    rd(14'h000, v); checks++;
    if (v[2:0] !== 3'b000) begin errors++; $display("FAIL ex_crmd got=%h exp=0", v[2:0]); end
    rd(14'h001, v); checks++;
    if (v[2:0] !== 3'b111) begin errors++; $display("FAIL ex_prmd got=%h exp=7", v[2:0]); end
    rd(14'h006, v); checks++;
    if (v !== 32'h1C00_0100 || ertn_era !== 32'h1C00_0100) begin
      errors++; $display("FAIL ex_era got=%h ertn_era=%h exp=1c000100", v, ertn_era);
    end
    rd(14'h005, v); checks++;
    if (v[21:16] !== 6'h0B) begin errors++; $display("FAIL ex_ecode got=%h exp=0b", v[21:16]); end
    ertn_flush = 1'b1;
    cycle();
    rd(14'h000, v); checks++;
    if (v[2:0] !== 3'b111) begin errors++; $display("FAIL ertn_crmd got=%h exp=7", v[2:0]); end

    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 8'hA5; wb_pc = 32'h1C00_0200;
    wb_vaddr = 32'h8000_0003;
    cycle();
    rd(14'h007, v); checks++;
    if (v !== 32'h8000_0003) begin errors++; $display("FAIL ale_badv got=%h exp=80000003", v); end
    rd(14'h005, v); checks++;
    if (v[30:22] !== 9'h0A5) begin errors++; $display("FAIL ex_esubcode got=%h exp=0a5", v[30:22]); end
    wb_ex = 1'b1; wb_ecode = 6'h0D; wb_pc = 32'h1C00_0300; wb_vaddr = 32'h0000_1111;
    cycle();
    rd(14'h007, v); checks++;
    if (v !== 32'h8000_0003) begin errors++; $display("FAIL other_badv got=%h exp=80000003", v); end
    wb_ex = 1'b1; wb_ecode = 6'h08; wb_pc = 32'h1C00_0404; wb_vaddr = 32'h0000_2222;
    cycle();
    rd(14'h007, v); checks++;
    if (v !== 32'h1C00_0404) begin errors++; $display("FAIL adef_badv got=%h exp=1c000404", v); end

    wr(14'h030, 32'hFFFF_FFFF, 32'h1234_5678);
    wb_ex = 1'b1; wb_ecode = 6'h0C; wb_pc = 32'h1C00_0500;
    csr_num = 14'h030; csr_we = 1'b1; csr_wmask = '1; csr_wvalue = 32'hDEAD_BEEF;
    cycle();
    rd(14'h030, v); checks++;
    if (v !== 32'h1234_5678) begin errors++; $display("FAIL ex_drops_we got=%h exp=12345678", v); end
    rd(14'h006, v); checks++;
    if (v !== 32'h1C00_0500) begin errors++; $display("FAIL ex_with_we_era got=%h exp=1c000500", v); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int unsigned sel;
    for (int unsigned n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        wb_ex = 1'b1;
        case ($urandom_range(0, 2))
          0: wb_ecode = 6'h08;
          1: wb_ecode = 6'h09;
          default: wb_ecode = 6'($urandom);
        endcase
        wb_esubcode = 8'($urandom); wb_pc = $urandom; wb_vaddr = $urandom;
      end
      if (sel == 1) ertn_flush = 1'b1;
      if (sel < 12) begin
        csr_num = addrs[$urandom_range(0, 16)];
        csr_we = 1'b1;
        csr_wmask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
        csr_wvalue = $urandom;
        if (csr_num == 14'h041) begin
          csr_wmask = '1; csr_wvalue = $urandom_range(0, 63);
        end
      end
      cycle();
      for (int unsigned i = 0; i < 17; i++) begin
        rd(addrs[i], v);
        checks++;
        if (v !== model_read(addrs[i])) begin
          errors++;
          $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, addrs[i], v, model_read(addrs[i]));
        end
      end
      checks++;
      if (has_int !== model_has_int() || ex_entry !== m_eentry || ertn_era !== m_era) begin
        errors++;
        $display("FAIL rand_outputs n=%0d has_int=%b/%b ex_entry=%h/%h ertn_era=%h/%h",
                 n, has_int, model_has_int(), ex_entry, m_eentry, ertn_era, m_era);
      end
    end
  endtask

`ifdef CSR_TIMER_EN
  task automatic test_timer();
    logic [31:0] v;
    int first, prev, hits;
    bit found;
    reset = 1'b1; model_reset(); #1; reset = 1'b0;
    @(posedge clk); #1;
    wr(14'h004, 32'h0000_0800, 32'h0000_0800);
    wr(14'h000, 32'h0000_0004, 32'h0000_0004);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0011);
    rd(14'h042, v); checks++;
    if (v !== 32'h0000_0010) begin errors++; $display("FAIL oneshot_load got=%h exp=00000010", v); end
    first = -1;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      rd(14'h042, v); checks++;
      if (v !== m_tval) begin errors++; $display("FAIL oneshot_tval k=%0d got=%h exp=%h", k, v, m_tval); end
      rd(14'h005, v);
      if (v[11] && first < 0) first = k;
    end
    checks++;
    if (first != 17) begin errors++; $display("FAIL oneshot_delay got=%0d exp=17", first); end
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL oneshot_stop got=%h exp=ffffffff", v); end
    checks++;
    if (has_int !== 1'b1) begin errors++; $display("FAIL timer_has_int got=%b exp=1", has_int); end
    wr(14'h044, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++;
    if (has_int !== 1'b0) begin errors++; $display("FAIL ticlr_has_int got=%b exp=0", has_int); end

    // Periodic, InitVal=1: expiries every 5 cycles; each is cleared next cycle.
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0007);
    prev = 0; hits = 0;
    for (int k = 1; k <= 26; k++) begin
      rd(14'h005, v);
      if (v[11]) begin csr_num = 14'h044; csr_we = 1'b1; csr_wmask = '1; csr_wvalue = 32'h1; end
      cycle();
      rd(14'h005, v); checks++;
      if (v !== m_estat) begin errors++; $display("FAIL periodic_estat k=%0d got=%h exp=%h", k, v, m_estat); end
      if (v[11]) begin
        hits++;
        checks++;
        if (k - prev != 5) begin errors++; $display("FAIL periodic_gap k=%0d got=%0d exp=5", k, k - prev); end
        prev = k;
      end
    end
    checks++;
    if (hits != 5) begin errors++; $display("FAIL periodic_count got=%0d exp=5", hits); end

    // TICLR issued on an expiry cycle: IS[11] must stay set.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      rd(14'h042, v);
      if (v == 32'd0) begin
        found = 1'b1;
        csr_num = 14'h044; csr_we = 1'b1; csr_wmask = '1; csr_wvalue = 32'h1;
      end
      cycle();
    end
    rd(14'h005, v); checks++;
    if (!found || v[11] !== 1'b1) begin
      errors++; $display("FAIL ticlr_vs_expiry found=%b is11=%b exp 1/1", found, v[11]);
    end

    // Asynchronous reset in mid-count, away from any clock edge.
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0401);
    cycle(); cycle();
    #20 reset = 1'b1;
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_reset_tval got=%h exp=ffffffff", v); end
    rd(14'h000, v); checks++;
    if (v !== 32'h0000_0008) begin errors++; $display("FAIL async_reset_crmd got=%h exp=00000008", v); end
    model_reset();
    @(posedge clk); #1;
    rd(14'h042, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_hold_tval got=%h exp=ffffffff", v); end
    reset = 1'b0;
  endtask
`else
  task automatic test_timer_absent();
    logic [31:0] v;
    wr(14'h040, 32'hFFFF_FFFF, 32'h5555_AAAA);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0007);
    for (int unsigned k = 0; k < 12; k++) cycle();
    for (int unsigned i = 11; i < 15; i++) begin
      rd(addrs[i], v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL no_timer_read addr=%h got=%h exp=0", addrs[i], v); end
    end
    rd(14'h005, v); checks++;
    if (v[11] !== 1'b0) begin errors++; $display("FAIL no_timer_is11 got=%b exp=0", v[11]); end
  endtask
`endif

  initial begin
    reset = 1'b1; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
    ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
    test_reset();
    test_exception();
    test_random();
`ifdef CSR_TIMER_EN
    test_timer();
`else
    test_timer_absent();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
